uart_top: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 63 ++++++
 rtl/uart_top.sv | 151 +++++++++++++++
 tb/tb_uart_top.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the receive-only UART.
//   rx_state_t        : receive FSM state encoding
//   DEF_CLKS_PER_BIT  : default system clocks per serial bit
//   DEF_DATA_BITS     : default payload bits per frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 7;
    localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received bytes.
//   clk      : system clock, rising edge
//   reset    : synchronous active-low reset (pointers and read register)
//   wr_en    : push wr_data (ignored when full)
//   wr_data  : byte to push
//   rd_en    : pop head into rd_data (ignored when empty)
//   rd_data  : most recently popped byte, held between pops
//   empty    : no entries stored
//   full     : FIFO_DEPTH entries stored
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_BITS,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr[AW-1:0]];
            end
        end
    end

    // Storage carries no reset; only pointer state defines validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_top.sv
// uart_top: receive-only UART with integrated receive FIFO.
//   clk      : system clock, rising edge
//   reset    : synchronous active-low reset
//   rd_en    : pop request from the client
//   d_out    : most recently popped byte
//   rx       : asynchronous serial input, idles high
//   rx_empty : receive FIFO holds no bytes
// Frames failing parity or stop-bit checks, or arriving while the FIFO is
// full, are dropped without any indication.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] d_out,
    input  logic                 rx,
    output logic                 rx_empty
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] FULL_T   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_T   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    // True when the received parity bit disagrees with the selected mode.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                        input logic p);
        return ((^d) ^ p) != ODD;
    endfunction

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 rx_p0;
    logic                 rx_p1;
    logic                 rx_s;
    logic [TW-1:0]        timer;
    logic                 timer_done;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 bad;
    logic                 wr_en;
    logic                 fifo_full;

    // Stage p0/p1: two-flop synchroniser, idles at the line's high level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    // START waits half a bit to land on the start-bit centre; every later
    // state waits a whole bit, keeping subsequent samples mid-bit.
    assign timer_done = (state == START) ? (timer == HALF_T) : (timer == FULL_T);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (timer_done) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (timer_done && bit_cnt == LAST_BIT)
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (timer_done) state_nxt = STOP;
            end
            STOP: begin
                if (timer_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en = 1'b0;
        if (state == STOP && timer_done && rx_s && !bad && !fifo_full)
            wr_en = 1'b1;
    end

    // Frame control: bit timer, bit counter and error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer   <= '0;
            bit_cnt <= '0;
            bad     <= 1'b0;
        end else begin
            if (state == IDLE || timer_done) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (state == IDLE) begin
                bit_cnt <= '0;
                bad     <= 1'b0;
            end else if (state == DATA && timer_done) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else if (state == PARITY && timer_done) begin
                bad <= parity_bad(shreg, rx_s);
            end
        end
    end

    // Shift right so the first (LSB) sample ends up in bit 0.
    always_ff @(posedge clk) begin
        if (state == DATA && timer_done) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    uart_rx_fifo #(
        .DATA_W     (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (shreg),
        .rd_en   (rd_en),
        .rd_data (d_out),
        .empty   (rx_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_uart_top.sv
module tb_uart_top;

    localparam int CPB = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_e, rx_o;
    logic       rd_e, rd_o;
    logic [7:0] dout_e, dout_o;
    logic       empty_e, empty_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_top dut_even (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_e),
        .d_out    (dout_e),
        .rx       (rx_e),
        .rx_empty (empty_e)
    );

    uart_top #(.PARITY_ODD(1)) dut_odd (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_o),
        .d_out    (dout_o),
        .rx       (rx_o),
        .rx_empty (empty_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; holds the level for n clocks.
    task automatic drive_bit(input bit odd, input logic v, input int n);
        if (odd) rx_o = v; else rx_e = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit odd, input logic [7:0] d, input logic par, input logic stp);
        drive_bit(odd, 1'b0, CPB);
        for (int k = 0; k < 8; k++) drive_bit(odd, d[k], CPB);
        drive_bit(odd, par, CPB);
        drive_bit(odd, stp, CPB);
        if (odd) rx_o = 1'b1; else rx_e = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_e = 1'b1;
        rx_o = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop(input bit odd);
        if (odd) rd_o = 1'b1; else rd_e = 1'b1;
        @(negedge clk);
        rd_o = 1'b0;
        rd_e = 1'b0;
    endtask

    logic [7:0] tab1 [17] = '{8'h11, 8'h9E, 8'h42, 8'hF0, 8'h07, 8'hD3, 8'h6B, 8'h80,
                               8'h2C, 8'hE1, 8'h55, 8'hAA, 8'h38, 8'hC7, 8'h00, 8'hFF, 8'h64};
    logic [7:0] tab2 [17] = '{8'h03, 8'h7D, 8'hB2, 8'h19, 8'hEE, 8'h40, 8'h8F, 8'h26,
                               8'hCA, 8'h51, 8'h9B, 8'h34, 8'hF7, 8'h6E, 8'h0D, 8'hA8, 8'h77};

    task automatic fill_and_drain(input logic [7:0] tab [17], input string tag);
        logic [7:0] b;
        for (int i = 0; i < 17; i++) begin
            b = tab[i];
            send_frame(1'b0, b, ^b, 1'b1);
        end
        idle(20);
        check({tag, "_notempty"}, empty_e, 1'b0);
        for (int i = 0; i < 16; i++) begin
            pop(1'b0);
            check($sformatf("%s_pop%0d", tag, i), dout_e, tab[i]);
        end
        check({tag, "_empty"}, empty_e, 1'b1);
        pop(1'b0);
        check({tag, "_hold"}, dout_e, tab[15]);
    endtask

    initial begin
        reset = 1'b0;
        rx_e = 1'b1; rx_o = 1'b1;
        rd_e = 1'b0; rd_o = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty_e", empty_e, 1'b1);
        check("rst_dout_e", dout_e, 8'h00);
        check("rst_empty_o", empty_o, 1'b1);
        check("rst_dout_o", dout_o, 8'h00);
        reset = 1'b1;
        idle(10);

        // even parity good frame
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        check("even_push", empty_e, 1'b0);
        idle(3);
        pop(1'b0);
        check("even_data", dout_e, 8'hA5);
        check("even_empty", empty_e, 1'b1);

        // odd parity
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1);
        send_frame(1'b1, 8'h01, 1'b0, 1'b1);
        idle(5);
        check("odd_push", empty_o, 1'b0);
        pop(1'b1);
        check("odd_d0", dout_o, 8'h3C);
        pop(1'b1);
        check("odd_d1", dout_o, 8'h01);
        check("odd_empty", empty_o, 1'b1);

        // parity error dropped, next good frame received
        fork
            send_frame(1'b0, 8'hA5, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 11 * CPB; i++) begin
                    @(posedge clk); #1;
                    if (empty_e !== 1'b1) check("perr_during", empty_e, 1'b1);
                end
            end
        join
        idle(10);
        check("perr_empty", empty_e, 1'b1);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        idle(3);
        pop(1'b0);
        check("perr_next", dout_e, 8'h5A);
        check("perr_next_empty", empty_e, 1'b1);

        // glitch
        drive_bit(1'b0, 1'b0, 2);
        idle(100);
        check("glitch_empty", empty_e, 1'b1);

        // framing error
        send_frame(1'b0, 8'h81, 1'b0, 1'b0);
        idle(30);
        check("frame_empty", empty_e, 1'b1);

        // FIFO full, overflow drop, and pointer wrap on the second round
        fill_and_drain(tab1, "fifo1");
        fill_and_drain(tab2, "fifo2");

        // reset during data bit 4
        drive_bit(1'b0, 1'b0, CPB);
        for (int k = 0; k < 4; k++) drive_bit(1'b0, 1'b0, CPB);
        drive_bit(1'b0, 1'b0, 3);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(120);
        check("rstmid_empty", empty_e, 1'b1);
        check("rstmid_dout", dout_e, 8'h00);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
        idle(3);
        check("rstmid_push", empty_e, 1'b0);
        pop(1'b0);
        check("rstmid_data", dout_e, 8'hC3);
        check("rstmid_final_empty", empty_e, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
